// File: rtl/bridge_arb_pkg.sv
// Shared types and constants for the CW305 bridge OBI arbiter.
package bridge_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef logic rq_idx_t;

    // Returned to the owner when the slave never answers.
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/bridge_rr_pick.sv
// Combinational two-way round-robin picker: a lone requester wins, a tie goes to
// whichever requester was not granted last.
module bridge_rr_pick
    import bridge_arb_pkg::*;
(
    input  logic [1:0] req,
    input  rq_idx_t    last,
    output logic       valid,
    output rq_idx_t    idx
);

    always_comb begin
        valid = |req;
        idx   = (req == 2'b11) ? ~last : req[1];
    end

endmodule

// File: rtl/bridge_obi_arbiter.sv
// Shares the X-HEEP OBI slave port between the loader (port 0) and the readback
// engine (port 1); one outstanding transaction, round-robin, response timeout.
module bridge_obi_arbiter
    import bridge_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned RESP_TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             rq_req,
    input  logic [1:0]             rq_we,
    input  logic [1:0][3:0]        rq_be,
    input  logic [1:0][ADDR_W-1:0] rq_addr,
    input  logic [1:0][DATA_W-1:0] rq_wdata,
    output logic [1:0]             rq_gnt,
    output logic [1:0]             rq_rvalid,
    output logic [DATA_W-1:0]      rq_rdata,
    output logic                   m_req,
    output logic                   m_we,
    output logic [3:0]             m_be,
    output logic [ADDR_W-1:0]      m_addr,
    output logic [DATA_W-1:0]      m_wdata,
    input  logic                   m_gnt,
    input  logic                   m_rvalid,
    input  logic [DATA_W-1:0]      m_rdata,
    output logic                   busy,
    output logic                   owner,
    input  logic                   err_clr,
    output logic                   err_timeout,
    output logic                   err_unexp_rvalid
);

    localparam int unsigned      CNT_W    = $clog2(RESP_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESP_TIMEOUT - 1);

    arb_state_e       state_q, state_d;
    rq_idx_t          owner_q, owner_d;
    rq_idx_t          last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_to_q, err_to_d;
    logic             err_ur_q, err_ur_d;
    logic             to_set;
    logic             ur_set;
    logic             pick_valid;
    rq_idx_t          pick_idx;

    bridge_rr_pick u_pick (
        .req   (rq_req),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        to_set    = 1'b0;
        m_req     = 1'b0;
        m_we      = 1'b0;
        m_be      = '0;
        m_addr    = '0;
        m_wdata   = '0;
        rq_gnt    = '0;
        rq_rvalid = '0;
        rq_rdata  = '0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    state_d = REQ;
                end
            end
            REQ: begin
                m_req           = rq_req[owner_q];
                m_we            = rq_we[owner_q];
                m_be            = rq_be[owner_q];
                m_addr          = rq_addr[owner_q];
                m_wdata         = rq_wdata[owner_q];
                rq_gnt[owner_q] = m_gnt;
                if (m_gnt) begin
                    last_d  = owner_q;
                    cnt_d   = '0;
                    state_d = RESP;
                end else if (!rq_req[owner_q]) begin
                    // Requester withdrew before the grant; fairness state untouched.
                    state_d = IDLE;
                end
            end
            RESP: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (m_rvalid) begin
                    rq_rvalid[owner_q] = 1'b1;
                    rq_rdata           = m_rdata;
                    state_d            = IDLE;
                end else if (cnt_q >= CNT_LAST) begin
                    rq_rvalid[owner_q] = 1'b1;
                    rq_rdata           = DATA_W'(TIMEOUT_RDATA);
                    to_set             = 1'b1;
                    state_d            = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A set event in the same cycle as err_clr takes priority over the clear.
    always_comb begin
        ur_set   = m_rvalid && (state_q != RESP);
        err_to_d = err_clr ? 1'b0 : err_to_q;
        err_ur_d = err_clr ? 1'b0 : err_ur_q;
        if (to_set) begin
            err_to_d = 1'b1;
        end
        if (ur_set) begin
            err_ur_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            err_to_q <= 1'b0;
            err_ur_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            err_to_q <= err_to_d;
            err_ur_q <= err_ur_d;
        end
    end

    assign busy             = (state_q != IDLE);
    assign owner            = owner_q;
    assign err_timeout      = err_to_q;
    assign err_unexp_rvalid = err_ur_q;

endmodule

// File: tb/tb_bridge_obi_arbiter.sv
// Scoreboard bench for bridge_obi_arbiter: directed transactions push expected grants
// and responses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_bridge_obi_arbiter;
    import bridge_arb_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]         rq_req;
    logic [1:0]         rq_we;
    logic [1:0][3:0]    rq_be;
    logic [1:0][AW-1:0] rq_addr;
    logic [1:0][DW-1:0] rq_wdata;
    logic [1:0]         rq_gnt;
    logic [1:0]         rq_rvalid;
    logic [DW-1:0]      rq_rdata;
    logic               m_req;
    logic               m_we;
    logic [3:0]         m_be;
    logic [AW-1:0]      m_addr;
    logic [DW-1:0]      m_wdata;
    logic               m_gnt;
    logic               m_rvalid;
    logic [DW-1:0]      m_rdata;
    logic               busy;
    logic               owner;
    logic               err_clr;
    logic               err_timeout;
    logic               err_unexp_rvalid;

    bridge_obi_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .RESP_TIMEOUT (TO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rq_req           (rq_req),
        .rq_we            (rq_we),
        .rq_be            (rq_be),
        .rq_addr          (rq_addr),
        .rq_wdata         (rq_wdata),
        .rq_gnt           (rq_gnt),
        .rq_rvalid        (rq_rvalid),
        .rq_rdata         (rq_rdata),
        .m_req            (m_req),
        .m_we             (m_we),
        .m_be             (m_be),
        .m_addr           (m_addr),
        .m_wdata          (m_wdata),
        .m_gnt            (m_gnt),
        .m_rvalid         (m_rvalid),
        .m_rdata          (m_rdata),
        .busy             (busy),
        .owner            (owner),
        .err_clr          (err_clr),
        .err_timeout      (err_timeout),
        .err_unexp_rvalid (err_unexp_rvalid)
    );

    typedef struct packed {
        logic          idx;
        logic          we;
        logic [3:0]    be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } gnt_exp_t;

    typedef struct packed {
        logic          idx;
        logic [DW-1:0] rdata;
    } rsp_exp_t;

    gnt_exp_t gnt_q[$];
    rsp_exp_t rsp_q[$];
    gnt_exp_t ge;
    rsp_exp_t re;

    int tests = 0;
    int fails = 0;
    int gnt_count = 0;
    int rsp_count = 0;
    int cyc = 0;
    int last_gnt_cyc = 0;
    int last_rsp_cyc = 0;
    int g0, r0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        cyc++;
        if (rq_gnt != 2'b00) begin
            gnt_count++;
            last_gnt_cyc = cyc;
            if (gnt_q.size() == 0) begin
                check("gnt_unexpected", 64'(rq_gnt), 64'd0);
            end else begin
                ge = gnt_q.pop_front();
                check("gnt_onehot", 64'($countones(rq_gnt)), 64'd1);
                check("gnt_idx", 64'(rq_gnt[1]), 64'(ge.idx));
                check("gnt_m_req", 64'(m_req), 64'd1);
                check("gnt_m_we", 64'(m_we), 64'(ge.we));
                check("gnt_m_be", 64'(m_be), 64'(ge.be));
                check("gnt_m_addr", 64'(m_addr), 64'(ge.addr));
                check("gnt_m_wdata", 64'(m_wdata), 64'(ge.wdata));
            end
        end
        if (rq_rvalid != 2'b00) begin
            rsp_count++;
            last_rsp_cyc = cyc;
            if (rsp_q.size() == 0) begin
                check("rvalid_unexpected", 64'(rq_rvalid), 64'd0);
            end else begin
                re = rsp_q.pop_front();
                check("rvalid_onehot", 64'($countones(rq_rvalid)), 64'd1);
                check("rvalid_idx", 64'(rq_rvalid[1]), 64'(re.idx));
                check("rvalid_rdata", 64'(rq_rdata), 64'(re.rdata));
            end
        end
        if (!busy) begin
            check("idle_m_ctl", 64'({m_req, m_we, m_be}), 64'd0);
            check("idle_m_data", {m_addr, m_wdata}, 64'd0);
        end
    end

    // Slave model; acts 2 time units after each rising edge
    logic          sl_en = 1'b1;
    logic          rv_en = 1'b1;
    logic          spur = 1'b0;
    int            gnt_wait = 0;
    logic [DW-1:0] sl_rdata = '0;
    int            wait_cnt = 0;
    logic          pend = 1'b0;

    initial begin
        m_gnt    = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
        forever begin
            @(posedge clk);
            #2;
            m_gnt    = 1'b0;
            m_rvalid = 1'b0;
            m_rdata  = sl_rdata;
            if (spur) m_rvalid = 1'b1;
            if (!rst_n) begin
                pend     = 1'b0;
                wait_cnt = 0;
            end else if (pend) begin
                pend = 1'b0;
                if (rv_en) m_rvalid = 1'b1;
            end else if (m_req && sl_en) begin
                if (wait_cnt >= gnt_wait) begin
                    m_gnt    = 1'b1;
                    pend     = 1'b1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int target);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            if (gnt_count >= target) break;
        end
        check("wait_gnt_bound", 64'(gnt_count >= target), 64'd1);
        #1;
    endtask

    task automatic wait_rsp(input int target);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            if (rsp_count >= target) break;
        end
        check("wait_rsp_bound", 64'(rsp_count >= target), 64'd1);
        #1;
    endtask

    task automatic set_fields(input logic idx, input logic we, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] wdata);
        rq_we[idx]    = we;
        rq_be[idx]    = be;
        rq_addr[idx]  = addr;
        rq_wdata[idx] = wdata;
    endtask

    task automatic xact(input logic idx, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata_exp);
        int gs;
        int rs;
        gs = gnt_count;
        rs = rsp_count;
        gnt_q.push_back(gnt_exp_t'{idx, we, be, addr, wdata});
        rsp_q.push_back(rsp_exp_t'{idx, rdata_exp});
        set_fields(idx, we, be, addr, wdata);
        rq_req[idx] = 1'b1;
        wait_gnt(gs + 1);
        rq_req[idx] = 1'b0;
        wait_rsp(rs + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rq_req   = '0;
        rq_we    = '0;
        rq_be    = '0;
        rq_addr  = '0;
        rq_wdata = '0;
        err_clr  = 1'b0;

        // Reset state
        #12;
        check("rst_outputs", 64'({busy, owner, m_req, rq_gnt, rq_rvalid, err_timeout,
                                  err_unexp_rvalid}), 64'd0);
        check("rst_rdata", 64'(rq_rdata), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single loader write, grant one cycle after m_req
        gnt_wait = 1;
        sl_rdata = 32'h0;
        xact(1'b0, 1'b1, 4'hF, 32'h0000_0180, 32'h0000_0013, 32'h0);
        check("t1_busy_after", 64'(busy), 64'd0);
        repeat (3) step();
        check("t1_gnt_total", 64'(gnt_count), 64'd1);
        check("t1_rsp_total", 64'(rsp_count), 64'd1);

        // Readback by requester 1
        gnt_wait = 0;
        sl_rdata = 32'hCAFE_F00D;
        xact(1'b1, 1'b0, 4'hF, 32'h0000_0004, 32'h0, 32'hCAFE_F00D);

        // Contention: both hold req for 4 transactions, expect 0,1,0,1
        sl_rdata = 32'h0000_0011;
        g0 = gnt_count;
        r0 = rsp_count;
        set_fields(1'b0, 1'b1, 4'hF, 32'h100, 32'hA0);
        set_fields(1'b1, 1'b0, 4'h3, 32'h200, 32'hB1);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) gnt_q.push_back(gnt_exp_t'{1'b0, 1'b1, 4'hF, 32'h100, 32'hA0});
            else            gnt_q.push_back(gnt_exp_t'{1'b1, 1'b0, 4'h3, 32'h200, 32'hB1});
            rsp_q.push_back(rsp_exp_t'{1'(i % 2), 32'h0000_0011});
        end
        rq_req = 2'b11;
        wait_gnt(g0 + 4);
        rq_req = 2'b00;
        wait_rsp(r0 + 4);

        // Timeout: slave never answers
        rv_en    = 1'b0;
        sl_rdata = 32'h5555_5555;
        xact(1'b0, 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEAD_BEEF);
        check("to_latency", 64'(last_rsp_cyc - last_gnt_cyc), 64'd8);
        check("to_err_set", 64'(err_timeout), 64'd1);
        check("to_unexp_quiet", 64'(err_unexp_rvalid), 64'd0);
        spur = 1'b1;
        step();
        spur = 1'b0;
        step();
        check("spur_err_set", 64'(err_unexp_rvalid), 64'd1);
        check("to_err_held", 64'(err_timeout), 64'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr_timeout", 64'(err_timeout), 64'd0);
        check("clr_unexp", 64'(err_unexp_rvalid), 64'd0);
        // Set and clear in the same cycle: set wins
        spur    = 1'b1;
        err_clr = 1'b1;
        step();
        spur    = 1'b0;
        err_clr = 1'b0;
        step();
        check("set_beats_clr", 64'(err_unexp_rvalid), 64'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr_again", 64'(err_unexp_rvalid), 64'd0);

        // Reset in the middle of RESP owned by requester 1
        g0 = gnt_count;
        gnt_q.push_back(gnt_exp_t'{1'b1, 1'b1, 4'h1, 32'h300, 32'h77});
        set_fields(1'b1, 1'b1, 4'h1, 32'h300, 32'h77);
        rq_req[1] = 1'b1;
        wait_gnt(g0 + 1);
        rq_req[1] = 1'b0;
        check("pre_rst_busy", 64'({busy, owner}), 64'b11);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_outputs", 64'({busy, owner, m_req, rq_gnt, rq_rvalid, err_timeout,
                                        err_unexp_rvalid}), 64'd0);
        check("rst_async_rdata", 64'(rq_rdata), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();

        // After reset requester 0 wins a tie
        rv_en    = 1'b1;
        sl_rdata = 32'h0000_0022;
        g0 = gnt_count;
        r0 = rsp_count;
        gnt_q.push_back(gnt_exp_t'{1'b0, 1'b0, 4'hF, 32'h400, 32'h0});
        rsp_q.push_back(rsp_exp_t'{1'b0, 32'h0000_0022});
        set_fields(1'b0, 1'b0, 4'hF, 32'h400, 32'h0);
        set_fields(1'b1, 1'b0, 4'hF, 32'h500, 32'h0);
        rq_req = 2'b11;
        wait_gnt(g0 + 1);
        rq_req = 2'b00;
        wait_rsp(r0 + 1);

        // Abort in REQ by requester 1; last grant stays with 0
        sl_en     = 1'b0;
        rq_req[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("abort_m_req_hi", 64'(m_req), 64'd1);
        check("abort_owner", 64'(owner), 64'd1);
        @(posedge clk);
        #1 rq_req[1] = 1'b0;
        @(negedge clk);
        check("abort_m_req_lo", 64'(m_req), 64'd0);
        @(negedge clk);
        check("abort_idle", 64'(busy), 64'd0);
        step();
        sl_en    = 1'b1;
        sl_rdata = 32'h0000_0033;
        g0 = gnt_count;
        r0 = rsp_count;
        gnt_q.push_back(gnt_exp_t'{1'b1, 1'b0, 4'hF, 32'h500, 32'h0});
        rsp_q.push_back(rsp_exp_t'{1'b1, 32'h0000_0033});
        rq_req = 2'b11;
        wait_gnt(g0 + 1);
        rq_req = 2'b00;
        wait_rsp(r0 + 1);

        repeat (3) step();
        check("gnt_q_drained", 64'(gnt_q.size()), 64'd0);
        check("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
